lcd_write_sequencer: RTL and testbench

Downstream consumer of the processor's LCD output register (io_lcd_o of `top`/`singlecycle`), placed between that 32-bit word and the HD44780-compatible character-LCD pins. Software writes one byte plus RS and raises a strobe bit. The block generates the bus timing: setup, enable pulse, hold and execution wait. A one-entry pending buffer absorbs a back-to-back write, and a sticky overflow flag reports strobes lost while both slots are occupied.

---
 rtl/lcd_write_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: converts byte writes from the processor LCD register
// into HD44780 write cycles (setup, enable pulse, hold, execution wait).
// A one-entry pending slot absorbs a back-to-back write; strobes arriving
// while both slots are occupied are dropped and flagged in a sticky bit.
//
// state | meaning
// IDLE  | no transaction, rs/data keep their last value
// SETUP | rs/data driven, en low
// PULSE | en high
// HOLD  | en low, rs/data held
// WAIT  | controller executing, short or long wait by command type
module lcd_write_sequencer #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 1850,
  parameter int LONG_WAIT_CYC = 76000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] io_lcd_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        lcd_busy_o,
  output logic        lcd_ovf_o
);

  localparam int CW = $clog2(LONG_WAIT_CYC + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strb_q, armed_q;
  logic          pend_vld_q, pend_vld_d;
  logic          pend_rs_q, pend_rs_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic          rs_d;
  logic [7:0]    data_d;
  logic          req, cnt_zero, wait_end, launch_pend, long_cmd, drop, ovf_d;
  logic          unused_io;

  assign unused_io = ^{io_lcd_i[30:12], io_lcd_i[9]};
  assign lcd_rw_o  = 1'b0;

  // armed_q masks the first sample after reset so a strobe already high is not an edge
  assign req         = io_lcd_i[10] & ~strb_q & armed_q;
  assign cnt_zero    = (cnt_q == '0);
  assign wait_end    = (state_q == ST_WAIT) && cnt_zero;
  assign launch_pend = pend_vld_q && ((state_q == ST_IDLE) || wait_end);
  assign long_cmd    = ~lcd_rs_o && ((lcd_data_o == 8'h01) || (lcd_data_o == 8'h02) ||
                                     (lcd_data_o == 8'h03));
  assign ovf_d       = drop | (lcd_ovf_o & ~io_lcd_i[11]);

  // Pending slot: store a request the FSM cannot take now; a slot being launched frees it
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    drop        = 1'b0;
    if (launch_pend) pend_vld_d = 1'b0;
    if (req && !((state_q == ST_IDLE) && !pend_vld_q)) begin
      if (!pend_vld_q || launch_pend) begin
        pend_vld_d  = 1'b1;
        pend_rs_d   = io_lcd_i[8];
        pend_data_d = io_lcd_i[7:0];
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Next state, counter reload and bus values on entry to SETUP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_ONE;
    rs_d    = lcd_rs_o;
    data_d  = lcd_data_o;
    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          rs_d    = pend_rs_q;
          data_d  = pend_data_q;
        end else if (req) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          rs_d    = io_lcd_i[8];
          data_d  = io_lcd_i[7:0];
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_PULSE;
          cnt_d   = EN_LD;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_WAIT;
          cnt_d   = long_cmd ? LONG_LD : WAIT_LD;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          if (pend_vld_q) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            rs_d    = pend_rs_q;
            data_d  = pend_data_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter, strobe history and pending slot registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      strb_q      <= 1'b0;
      armed_q     <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      strb_q      <= io_lcd_i[10];
      armed_q     <= 1'b1;
      pend_vld_q  <= pend_vld_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Registered pin outputs, derived from next-state values so they align with the state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lcd_data_o <= 8'h00;
      lcd_rs_o   <= 1'b0;
      lcd_en_o   <= 1'b0;
      lcd_on_o   <= 1'b0;
      lcd_busy_o <= 1'b0;
      lcd_ovf_o  <= 1'b0;
    end else begin
      lcd_data_o <= data_d;
      lcd_rs_o   <= rs_d;
      lcd_en_o   <= (state_d == ST_PULSE);
      lcd_on_o   <= io_lcd_i[31];
      lcd_busy_o <= (state_d != ST_IDLE) | pend_vld_d;
      lcd_ovf_o  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: directed timing scenarios followed by
// randomized register writes compared against a transaction-level model
// that tracks each write by its launch cycle and total duration.
module tb_lcd_write_sequencer;

  localparam int S  = 2;
  localparam int EN = 3;
  localparam int H  = 2;
  localparam int W  = 5;
  localparam int L  = 20;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [31:0] io_lcd_i = 32'h0;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_busy_o, lcd_ovf_o;

  lcd_write_sequencer #(
    .SETUP_CYC(S), .EN_CYC(EN), .HOLD_CYC(H), .WAIT_CYC(W), .LONG_WAIT_CYC(L)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .io_lcd_i(io_lcd_i),
    .lcd_data_o(lcd_data_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
    .lcd_en_o(lcd_en_o), .lcd_on_o(lcd_on_o), .lcd_busy_o(lcd_busy_o),
    .lcd_ovf_o(lcd_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  bit         m_prev, m_armed, m_active, m_pend, m_ovf, m_on;
  logic       m_rs, m_prs;
  logic [7:0] m_data, m_pdata;
  int         m_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  function automatic int dur_of(input logic rs, input logic [7:0] d);
    return S + EN + H + ((!rs && d >= 8'h01 && d <= 8'h03) ? L : W);
  endfunction

  task automatic m_launch(input int t, input logic rs, input logic [7:0] d);
    m_active = 1'b1;
    m_start  = t;
    m_rs     = rs;
    m_data   = d;
  endtask

  task automatic m_store(input logic [31:0] in);
    m_pend  = 1'b1;
    m_prs   = in[8];
    m_pdata = in[7:0];
  endtask

  // One clock edge t of the model with input word in
  task automatic model_edge(input logic [31:0] in, input int t);
    bit req, drop;
    req    = m_armed && in[10] && !m_prev;
    m_prev = in[10];
    m_armed = 1'b1;
    drop   = 1'b0;
    if (!m_active) begin
      if (m_pend) begin
        m_launch(t, m_prs, m_pdata);
        m_pend = 1'b0;
        if (req) m_store(in);
      end else if (req) begin
        m_launch(t, in[8], in[7:0]);
      end
    end else if (t == m_start + dur_of(m_rs, m_data)) begin
      if (m_pend) begin
        m_launch(t, m_prs, m_pdata);
        m_pend = 1'b0;
      end else begin
        m_active = 1'b0;
      end
      if (req) m_store(in);
    end else if (req) begin
      if (!m_pend) m_store(in);
      else drop = 1'b1;
    end
    m_ovf = drop ? 1'b1 : (in[11] ? 1'b0 : m_ovf);
    m_on  = in[31];
  endtask

  task automatic single(input logic rs, input logic [7:0] d, input int total, input string tag);
    io_lcd_i = 32'h0;
    tick();
    io_lcd_i = 32'h0000_0400 | {23'h0, rs, d};
    tick();
    check({tag, "_rs"}, lcd_rs_o, rs);
    check({tag, "_data"}, lcd_data_o, d);
    check({tag, "_busy0"}, lcd_busy_o, 1'b1);
    io_lcd_i[10] = 1'b0;
    for (int k = 1; k <= total + 2; k++) begin
      tick();
      check($sformatf("%s_en@%0d", tag, k), lcd_en_o, (k >= S && k < S + EN));
      check($sformatf("%s_busy@%0d", tag, k), lcd_busy_o, (k < total));
    end
  endtask

  initial begin
    int ens;
    bit pe;
    int dens;
    logic [31:0] w;
    logic [7:0] d;

    // reset with every input bit high
    io_lcd_i = 32'hFFFF_FFFF;
    rst_ni = 1'b0;
    tick();
    tick();
    check("rst_data", lcd_data_o, 8'h00);
    check("rst_rs", lcd_rs_o, 1'b0);
    check("rst_rw", lcd_rw_o, 1'b0);
    check("rst_en", lcd_en_o, 1'b0);
    check("rst_on", lcd_on_o, 1'b0);
    check("rst_busy", lcd_busy_o, 1'b0);
    check("rst_ovf", lcd_ovf_o, 1'b0);
    rst_ni = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("rel_en@%0d", k), lcd_en_o, 1'b0);
      check($sformatf("rel_busy@%0d", k), lcd_busy_o, 1'b0);
      if (k == 1) check("rel_on", lcd_on_o, 1'b1);
    end

    single(1'b1, 8'h41, 12, "data41");
    single(1'b0, 8'h01, 27, "clear");
    single(1'b1, 8'h01, 12, "data01");
    single(1'b0, 8'h02, 27, "home");
    single(1'b0, 8'h38, 12, "func");

    // back-to-back writes
    io_lcd_i = 32'h0;
    tick();
    io_lcd_i = 32'h0000_0541;
    tick();
    for (int k = 1; k <= 26; k++) begin
      io_lcd_i = (k == 4) ? 32'h0000_0542 : 32'h0000_0100;
      tick();
      check($sformatf("b2b_en@%0d", k), lcd_en_o,
            ((k >= 2 && k < 5) || (k >= 14 && k < 17)));
      check($sformatf("b2b_busy@%0d", k), lcd_busy_o, (k < 24));
      if (k == 11) check("b2b_data_first", lcd_data_o, 8'h41);
      if (k == 12) check("b2b_data_second", lcd_data_o, 8'h42);
    end
    check("b2b_ovf", lcd_ovf_o, 1'b0);

    // overflow: third strobe within one transaction
    io_lcd_i = 32'h0;
    tick();
    io_lcd_i = 32'h0000_0541;
    tick();
    ens = 0;
    pe = lcd_en_o;
    for (int k = 1; k <= 30; k++) begin
      io_lcd_i = (k == 2) ? 32'h0000_0542 : (k == 4) ? 32'h0000_0543 : 32'h0000_0100;
      tick();
      if (lcd_en_o && !pe) ens++;
      pe = lcd_en_o;
      if (k == 4) check("ovf_set", lcd_ovf_o, 1'b1);
    end
    check("ovf_pulses", ens, 2);
    check("ovf_last_data", lcd_data_o, 8'h42);
    check("ovf_idle", lcd_busy_o, 1'b0);
    check("ovf_sticky", lcd_ovf_o, 1'b1);
    io_lcd_i = 32'h0000_0800;
    tick();
    check("ovf_clear", lcd_ovf_o, 1'b0);

    // drop and clear in the same cycle: drop wins
    io_lcd_i = 32'h0;
    tick();
    io_lcd_i = 32'h0000_0541;
    tick();
    for (int k = 1; k <= 30; k++) begin
      io_lcd_i = (k == 2) ? 32'h0000_0542 : (k == 4) ? 32'h0000_0D43 : 32'h0000_0100;
      tick();
      if (k == 4) check("ovf_drop_wins", lcd_ovf_o, 1'b1);
    end
    check("ovf_drop_sticky", lcd_ovf_o, 1'b1);

    // reset during PULSE with a write pending
    io_lcd_i = 32'h0;
    tick();
    io_lcd_i = 32'h0000_0541;
    tick();
    io_lcd_i = 32'h0000_0100;
    tick();
    io_lcd_i = 32'h0000_0542;
    tick();
    check("mid_en_before", lcd_en_o, 1'b1);
    io_lcd_i = 32'h0000_0100;
    tick();
    rst_ni = 1'b0;
    #1;
    check("mid_en", lcd_en_o, 1'b0);
    check("mid_busy", lcd_busy_o, 1'b0);
    check("mid_data", lcd_data_o, 8'h00);
    check("mid_ovf", lcd_ovf_o, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("mid_after_en@%0d", k), lcd_en_o, 1'b0);
      check($sformatf("mid_after_busy@%0d", k), lcd_busy_o, 1'b0);
    end

    // randomized writes against the model
    io_lcd_i = 32'h0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    m_prev = 0; m_armed = 0; m_active = 0; m_pend = 0; m_ovf = 0; m_on = 0;
    m_rs = 0; m_prs = 0; m_data = 8'h00; m_pdata = 8'h00; m_start = 0;
    dens = 4;
    for (int n = 0; n < 2400; n++) begin
      if (n % 300 == 0) dens = (n % 900 == 0) ? 3 : (n % 600 == 0) ? 10 : 25;
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      w = $urandom & 32'h7FFF_F200;
      w[31] = ($urandom_range(0, 1) == 1);
      w[11] = ($urandom_range(0, 15) == 0);
      w[10] = ($urandom_range(0, dens - 1) == 0);
      w[8]  = ($urandom_range(0, 1) == 1);
      w[7:0] = d;
      io_lcd_i = w;
      model_edge(w, cyc + 1);
      tick();
      check($sformatf("rnd_en@%0d", cyc), lcd_en_o,
            (m_active && (cyc - m_start) >= S && (cyc - m_start) < S + EN));
      check($sformatf("rnd_busy@%0d", cyc), lcd_busy_o, (m_active || m_pend));
      check($sformatf("rnd_rs@%0d", cyc), lcd_rs_o, m_rs);
      check($sformatf("rnd_data@%0d", cyc), lcd_data_o, m_data);
      check($sformatf("rnd_ovf@%0d", cyc), lcd_ovf_o, m_ovf);
      check($sformatf("rnd_on@%0d", cyc), lcd_on_o, m_on);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
